// File: rtl/jt12_fnum_pkg.sv
// Shared constants and types for the channel frequency register writer.
// Register groups are matched on addr[7:2]; addr[1:0] selects the channel in the group.
package jt12_fnum_pkg;

  localparam logic [7:0] A_FNUM_LO = 8'hA0;
  localparam logic [7:0] A_FNUM_HI = 8'hA4;
  localparam logic [7:0] A_C3_LO   = 8'hA8;
  localparam logic [7:0] A_C3_HI   = 8'hAC;

  localparam int MAX_CH       = 6;
  localparam int SLOTS_PER_CH = 4;

  typedef struct packed {
    logic [2:0]  blk;
    logic [10:0] fn;
  } fnblk_t;

  // True when addr falls in the three-entry group starting at base (index 3 never decodes)
  function automatic logic addr_hit(input logic [7:0] addr, input logic [7:0] base);
    return (addr[7:2] == base[7:2]) && (addr[1:0] != 2'd3);
  endfunction

endpackage

// File: rtl/jt12_fnum_seq.sv
// Slot sequencer: 5-bit slot counter in op-major order (slot = op*NUM_CH + ch),
// with the channel/operator indices tracked alongside so no divider is needed.
module jt12_fnum_seq
  import jt12_fnum_pkg::*;
#(
  parameter int NUM_CH = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  output logic [2:0] ch,
  output logic [1:0] op,
  output logic       sync
);

  localparam logic [4:0] LAST_SLOT = 5'(SLOTS_PER_CH * NUM_CH - 1);
  localparam logic [2:0] LAST_CH   = 3'(NUM_CH - 1);

  logic [4:0] cnt;

  // Advance the slot counter and its ch/op decode together on each clock enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      ch  <= '0;
      op  <= '0;
    end else if (cen) begin
      if (cnt == LAST_SLOT) begin
        cnt <= '0;
        ch  <= '0;
        op  <= '0;
      end else begin
        cnt <= cnt + 5'd1;
        if (ch == LAST_CH) begin
          ch <= '0;
          op <= op + 2'd1;
        end else begin
          ch <= ch + 3'd1;
        end
      end
    end
  end

  assign sync = (cnt == 5'd0);

endmodule

// File: rtl/jt12_fnum_wr.sv
// Channel frequency register writer (0xA0-0xAE) with time-multiplexed replay.
// MSB writes load a latch, LSB writes commit {latch, data}; ch3 special-mode slots
// have their own latch. Optional debug readback port under JT12_FNUM_DBG_EN.
module jt12_fnum_wr
  import jt12_fnum_pkg::*;
#(
  parameter int NUM_CH = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        wr,
  input  logic        part,
  input  logic [7:0]  addr,
  input  logic [7:0]  din,
  input  logic        ch3_sp,
  output logic [2:0]  block,
  output logic [10:0] fnum,
  output logic [2:0]  slot_ch,
  output logic [1:0]  slot_op,
  output logic        sync
`ifdef JT12_FNUM_DBG_EN
  ,
  input  logic [3:0]  dbg_sel,
  output logic [13:0] dbg_out
`endif
);

  fnblk_t     ch_reg [MAX_CH];
  fnblk_t     c3x    [3];
  logic [5:0] lat_main;
  logic [5:0] lat_c3;

  logic       wr_ok;
  logic [2:0] chn;

  // A 3-channel build has no upper part, so its writes are dropped entirely
  assign wr_ok = wr && ((NUM_CH == MAX_CH) || !part);
  assign chn   = {1'b0, addr[1:0]} + (part ? 3'd3 : 3'd0);

  // Write capture runs on every clk; latches persist across commits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_main <= '0;
      lat_c3   <= '0;
      for (int i = 0; i < MAX_CH; i++) ch_reg[i] <= '0;
      for (int i = 0; i < 3; i++) c3x[i] <= '0;
    end else if (wr_ok) begin
      if (addr_hit(addr, A_FNUM_HI)) lat_main <= din[5:0];
      if (addr_hit(addr, A_FNUM_LO)) ch_reg[chn] <= {lat_main, din};
      if (addr_hit(addr, A_C3_HI)) lat_c3 <= din[5:0];
      if (addr_hit(addr, A_C3_LO) && !part) c3x[addr[1:0]] <= {lat_c3, din};
    end
  end

  // ---- stage p0: slot counter and register lookup ----
  logic [2:0] cur_ch_p0;
  logic [1:0] cur_op_p0;
  logic       sync_p0;
  fnblk_t     look_p0;

  jt12_fnum_seq #(
    .NUM_CH (NUM_CH)
  ) u_seq (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .ch    (cur_ch_p0),
    .op    (cur_op_p0),
    .sync  (sync_p0)
  );

  // Select the stored value for the current slot; ch3 special mode overrides ops 0-2
  always_comb begin
    look_p0 = ch_reg[cur_ch_p0];
    if (ch3_sp && (cur_ch_p0 == 3'd2)) begin
      case (cur_op_p0)
        2'd0:    look_p0 = c3x[0];
        2'd1:    look_p0 = c3x[1];
        2'd2:    look_p0 = c3x[2];
        default: look_p0 = ch_reg[cur_ch_p0];
      endcase
    end
  end

  // ---- stage p1: registered outputs (a same-edge commit is seen next visit) ----
  // Register the looked-up value together with its slot tags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      block   <= '0;
      fnum    <= '0;
      slot_ch <= '0;
      slot_op <= '0;
      sync    <= 1'b0;
    end else if (cen) begin
      block   <= look_p0.blk;
      fnum    <= look_p0.fn;
      slot_ch <= cur_ch_p0;
      slot_op <= cur_op_p0;
      sync    <= sync_p0;
    end
  end

`ifdef JT12_FNUM_DBG_EN
  // Combinational readback: codes 0-5 channel registers, 8-10 ch3 special slots
  always_comb begin
    dbg_out = '0;
    if (dbg_sel < 4'd6)
      dbg_out = ch_reg[dbg_sel[2:0]];
    else if ((dbg_sel >= 4'd8) && (dbg_sel <= 4'd10))
      dbg_out = c3x[dbg_sel[1:0]];
  end
`endif

endmodule

// File: tb/tb_jt12_fnum_wr.sv
// Directed bench for jt12_fnum_wr: a 6-channel and a 3-channel instance share all inputs.
module tb_jt12_fnum_wr;

  logic        clk = 1'b0;
  logic        rst_n, cen, wr, part, ch3_sp;
  logic [7:0]  addr, din;

  logic [2:0]  blk6, blk3, sch6, sch3;
  logic [10:0] fn6, fn3;
  logic [1:0]  op6, op3;
  logic        sy6, sy3;
`ifdef JT12_FNUM_DBG_EN
  logic [3:0]  dbg_sel = 4'd0;
  logic [13:0] dbg6, dbg3;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  jt12_fnum_wr #(.NUM_CH(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .wr(wr), .part(part), .addr(addr), .din(din),
    .ch3_sp(ch3_sp), .block(blk6), .fnum(fn6), .slot_ch(sch6), .slot_op(op6), .sync(sy6)
`ifdef JT12_FNUM_DBG_EN
    , .dbg_sel(dbg_sel), .dbg_out(dbg6)
`endif
  );

  jt12_fnum_wr #(.NUM_CH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .wr(wr), .part(part), .addr(addr), .din(din),
    .ch3_sp(ch3_sp), .block(blk3), .fnum(fn3), .slot_ch(sch3), .slot_op(op3), .sync(sy3)
`ifdef JT12_FNUM_DBG_EN
    , .dbg_sel(dbg_sel), .dbg_out(dbg3)
`endif
  );

  typedef struct packed {
    logic        do_wr;
    logic        part;
    logic [7:0]  addr;
    logic [7:0]  din;
    logic        sp;
    logic [2:0]  ch;
    logic [1:0]  op;
    logic [2:0]  blk;
    logic [10:0] fn;
  } vec_t;

  localparam int NV = 22;
  vec_t vt [NV];

  function automatic vec_t mk(input logic w, input logic p, input logic [7:0] a, input logic [7:0] d,
                              input logic sp, input logic [2:0] c, input logic [1:0] o,
                              input logic [2:0] b, input logic [10:0] f);
    vec_t v;
    v.do_wr = w; v.part = p; v.addr = a; v.din = d; v.sp = sp;
    v.ch = c; v.op = o; v.blk = b; v.fn = f;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; the write is captured on the following posedge
  task automatic do_write(input logic p, input logic [7:0] a, input logic [7:0] d);
    part = p; addr = a; din = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic wait_slot(input bit d3, input logic [2:0] c, input logic [1:0] o,
                           output logic [2:0] b, output logic [10:0] f);
    bit found;
    found = 1'b0;
    b = '0; f = '0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (d3 ? (sch3 == c && op3 == o) : (sch6 == c && op6 == o)) begin
        found = 1'b1;
        b = d3 ? blk3 : blk6;
        f = d3 ? fn3 : fn6;
      end
    end
    if (!found) begin
      n_vec++; n_err++;
      $display("FAIL slot_timeout: dut%0d ch %0d op %0d never seen, required within 60 clk", d3 ? 3 : 6, c, o);
    end
  endtask

  // Slot order and sync from the first cen after reset release; stored values all zero
  task automatic check_seq(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("seq6_%0d", i), 32'({sch6, op6, sy6, blk6, fn6}),
            32'({3'(i % 6), 2'((i / 6) % 4), (i % 24) == 0, 14'd0}));
      check($sformatf("seq3_%0d", i), 32'({sch3, op3, sy3, blk3, fn3}),
            32'({3'(i % 3), 2'((i / 3) % 4), (i % 12) == 0, 14'd0}));
    end
  endtask

  logic [2:0]  gb;
  logic [10:0] gf;

  initial begin
    vt[0]  = mk(0, 0, 8'h00, 8'h00, 0, 3'd0, 2'd0, 3'd0, 11'h000);
    vt[1]  = mk(1, 0, 8'hA4, 8'h2A, 0, 3'd0, 2'd2, 3'd0, 11'h000);
    vt[2]  = mk(1, 0, 8'hA0, 8'h55, 0, 3'd0, 2'd0, 3'd5, 11'h255);
    vt[3]  = mk(0, 0, 8'h00, 8'h00, 0, 3'd0, 2'd3, 3'd5, 11'h255);
    vt[4]  = mk(1, 0, 8'hA4, 8'h13, 0, 3'd0, 2'd1, 3'd5, 11'h255);
    vt[5]  = mk(1, 0, 8'hA1, 8'h00, 0, 3'd1, 2'd0, 3'd2, 11'h300);
    vt[6]  = mk(1, 0, 8'hA2, 8'hFF, 0, 3'd2, 2'd2, 3'd2, 11'h3FF);
    vt[7]  = mk(1, 0, 8'hAC, 8'h09, 1, 3'd2, 2'd1, 3'd0, 11'h000);
    vt[8]  = mk(1, 0, 8'hA9, 8'h80, 1, 3'd2, 2'd1, 3'd1, 11'h180);
    vt[9]  = mk(0, 0, 8'h00, 8'h00, 1, 3'd2, 2'd3, 3'd2, 11'h3FF);
    vt[10] = mk(1, 0, 8'hA0, 8'h11, 1, 3'd0, 2'd0, 3'd2, 11'h311);
    vt[11] = mk(0, 0, 8'h00, 8'h00, 0, 3'd2, 2'd1, 3'd2, 11'h3FF);
    vt[12] = mk(1, 1, 8'hA4, 8'h3F, 0, 3'd0, 2'd2, 3'd2, 11'h311);
    vt[13] = mk(1, 1, 8'hA2, 8'h01, 0, 3'd5, 2'd3, 3'd7, 11'h701);
    vt[14] = mk(1, 1, 8'hA6, 8'h21, 0, 3'd5, 2'd0, 3'd7, 11'h701);
    vt[15] = mk(1, 1, 8'hA0, 8'hAB, 0, 3'd3, 2'd1, 3'd4, 11'h1AB);
    vt[16] = mk(1, 0, 8'hA3, 8'h77, 0, 3'd3, 2'd0, 3'd4, 11'h1AB);
    vt[17] = mk(1, 1, 8'hA8, 8'h44, 1, 3'd2, 2'd0, 3'd0, 11'h000);
    vt[18] = mk(1, 0, 8'hA8, 8'h44, 1, 3'd2, 2'd0, 3'd1, 11'h144);
    vt[19] = mk(1, 0, 8'hAE, 8'h3A, 1, 3'd2, 2'd2, 3'd0, 11'h000);
    vt[20] = mk(1, 0, 8'hAA, 8'h02, 1, 3'd2, 2'd2, 3'd7, 11'h202);
    vt[21] = mk(1, 0, 8'hA1, 8'h00, 1, 3'd1, 2'd3, 3'd4, 11'h100);

    rst_n = 1'b0; cen = 1'b1; wr = 1'b0; part = 1'b0; addr = 8'h00; din = 8'h00; ch3_sp = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst6", 32'({sch6, op6, sy6, blk6, fn6}), 32'd0);
    check("rst3", 32'({sch3, op3, sy3, blk3, fn3}), 32'd0);
    rst_n = 1'b1;
    check_seq(50);

    // Table of write/lookup vectors on the 6-channel instance
    for (int i = 0; i < NV; i++) begin
      ch3_sp = vt[i].sp;
      if (vt[i].do_wr) do_write(vt[i].part, vt[i].addr, vt[i].din);
      wait_slot(1'b0, vt[i].ch, vt[i].op, gb, gf);
      check($sformatf("vec%0d", i), 32'({gb, gf}), 32'({vt[i].blk, vt[i].fn}));
    end

    // Commit to ch1 on the same edge that looks up ch1: old value now, new value next visit
    ch3_sp = 1'b0;
    do_write(1'b0, 8'hA4, 8'h05);
    wait_slot(1'b0, 3'd0, 2'd0, gb, gf);
    part = 1'b0; addr = 8'hA1; din = 8'h66; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    check("collide_old", 32'({sch6, op6, blk6, fn6}), 32'({3'd1, 2'd0, 3'd4, 11'h100}));
    wait_slot(1'b0, 3'd1, 2'd1, gb, gf);
    check("collide_new", 32'({gb, gf}), 32'({3'd0, 11'h566}));

    // Upper-part writes are dropped by the 3-channel build, including the shared latch
    do_write(1'b1, 8'hA4, 8'h2A);
    do_write(1'b0, 8'hA1, 8'h77);
    wait_slot(1'b0, 3'd1, 2'd2, gb, gf);
    check("p1_lat6", 32'({gb, gf}), 32'({3'd5, 11'h277}));
    wait_slot(1'b1, 3'd1, 2'd2, gb, gf);
    check("p1_lat3", 32'({gb, gf}), 32'({3'd0, 11'h577}));
    do_write(1'b1, 8'hA0, 8'h99);
    wait_slot(1'b0, 3'd3, 2'd0, gb, gf);
    check("p1_a0_6", 32'({gb, gf}), 32'({3'd5, 11'h299}));
    wait_slot(1'b1, 3'd0, 2'd0, gb, gf);
    check("p1_a0_3", 32'({gb, gf}), 32'({3'd2, 11'h311}));

    // cen low freezes the sequence while writes are still captured
    wait_slot(1'b0, 3'd0, 2'd1, gb, gf);
    cen = 1'b0;
    do_write(1'b0, 8'hA2, 8'h5A);
    @(negedge clk);
    @(negedge clk);
    check("cen_hold", 32'({sch6, op6, blk6, fn6}), 32'({3'd0, 2'd1, 3'd2, 11'h311}));
    cen = 1'b1;
    @(negedge clk);
    check("cen_resume", 32'({sch6, op6, blk6, fn6}), 32'({3'd1, 2'd1, 3'd5, 11'h277}));
    wait_slot(1'b0, 3'd2, 2'd0, gb, gf);
    check("cen_wr", 32'({gb, gf}), 32'({3'd5, 11'h25A}));

    // Asynchronous reset mid-frame clears immediately; sequence restarts at slot 0
    wait_slot(1'b0, 3'd0, 2'd0, gb, gf);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst6", 32'({sch6, op6, sy6, blk6, fn6}), 32'd0);
    check("mid_rst3", 32'({sch3, op3, sy3, blk3, fn3}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_seq(26);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
